instr_encoder_loader: RTL and testbench

Assembles MIPS instruction words from field-level requests and writes them sequentially into instruction memory. It performs the inverse of the opcode decoder: the decoder turns words into control, and this block turns operation kinds and fields into words. It sits between the testbench or boot host and the instruction memory write port, and loads a program before the core runs.

---
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: builds MIPS words from field requests
// and streams them into instruction memory one word per two cycles.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              finish,
  input  logic              clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err_illegal
);

  typedef enum logic [1:0] {
    ACCEPT,
    WRITE,
    FULL,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] LastCount = {1'b0, {ADDR_W{1'b1}}};

  state_t      state;
  logic        finishPending;
  logic        legal;
  logic        handshake;
  logic [31:0] word;

  assign in_ready  = (state == ACCEPT);
  assign handshake = in_valid & in_ready;

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (op_kind)
      4'd0:    word = {6'b000000, rs, rt, rd, shamt, funct};
      4'd1:    word = {6'b001000, rs, rt, imm};
      4'd2:    word = {6'b001100, rs, rt, imm};
      4'd3:    word = {6'b001101, rs, rt, imm};
      4'd4:    word = {6'b001010, rs, rt, imm};
      4'd5:    word = {6'b000100, rs, rt, imm};
      4'd6:    word = {6'b000101, rs, rt, imm};
      4'd7:    word = {6'b000010, target};
      4'd8:    word = {6'b000011, target};
      4'd9:    word = {6'b100011, rs, rt, imm};
      4'd10:   word = {6'b101011, rs, rt, imm};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ACCEPT;
      finishPending <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      count         <= '0;
      full          <= 1'b0;
      done          <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ACCEPT: begin
          if (handshake && legal) begin
            mem_we        <= 1'b1;
            mem_addr      <= count[ADDR_W-1:0];
            mem_wdata     <= word;
            finishPending <= finish;
            state         <= WRITE;
          end else begin
            if (handshake) err_illegal <= 1'b1;
            if (finish) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        WRITE: begin
          count         <= count + 1'b1;
          finishPending <= 1'b0;
          // the last slot wins over a pending finish: memory is full
          if (count == LastCount) begin
            full  <= 1'b1;
            state <= FULL;
          end else if (finishPending) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ACCEPT;
          end
        end
        FULL: begin
          if (clear) begin
            count       <= '0;
            full        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            state       <= ACCEPT;
          end else if (finish) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (clear) begin
            count       <= '0;
            full        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            state       <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with ADDR_W = 2:
// stimulus pushes expected writes, a monitor pops them on mem_we.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_kind;
  logic [4:0]    rs, rt, rd, shamt;
  logic [5:0]    funct;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          finish;
  logic          clear;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic          err_illegal;

  int nChecks = 0;
  int nFail = 0;

  logic [AW-1:0] expAddrQ[$];
  logic [31:0]   expDataQ[$];

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .target(target),
    .finish(finish), .clear(clear),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .done(done),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      if (expDataQ.size() == 0) begin
        check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(mem_addr), 32'(expAddrQ.pop_front()));
        check("wr_data", mem_wdata, expDataQ.pop_front());
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d,
                      input logic [4:0] sh, input logic [5:0] f,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic fin, input logic push,
                      input logic [AW-1:0] ea, input logic [31:0] ew);
    op_kind = k; rs = s; rt = t; rd = d; shamt = sh;
    funct = f; imm = im; target = tg;
    in_valid = 1'b1;
    finish = fin;
    if (push) begin
      expAddrQ.push_back(ea);
      expDataQ.push_back(ew);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish = 1'b0;
  endtask

  task automatic pulse(input logic isClear);
    @(negedge clk);
    if (isClear) clear = 1'b1;
    else finish = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; finish = 1'b0; clear = 1'b0;
    op_kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0;
    funct = '0; imm = '0; target = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {29'd0, full, done, err_illegal}, 32'd0);

    // R-type
    waitReady();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0,
         1'b0, 1'b1, 2'd0, 32'h0022_1820);
    waitReady();
    check("r_count", 32'(count), 32'd1);
    pulse(1'b0);
    check("r_done", 32'(done), 32'd1);
    pulse(1'b1);
    check("clr_count", 32'(count), 32'd0);

    // I-type sequence
    waitReady();
    send(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0,
         1'b0, 1'b1, 2'd0, 32'h2022_0005);
    waitReady();
    send(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0,
         1'b0, 1'b1, 2'd1, 32'h1022_FFFF);
    waitReady();
    send(4'd9, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0,
         1'b0, 1'b1, 2'd2, 32'h8FA8_0004);
    waitReady();
    check("i_count", 32'(count), 32'd3);
    pulse(1'b0);
    pulse(1'b1);

    // J-type, illegal, then fill to FULL
    waitReady();
    send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000100,
         1'b0, 1'b1, 2'd0, 32'h0800_0100);
    waitReady();
    send(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000100,
         1'b0, 1'b1, 2'd1, 32'h0C00_0100);
    waitReady();
    send(4'hF, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F, 16'h1234, 26'h0,
         1'b0, 1'b0, 2'd0, 32'h0);
    check("ill_err", 32'(err_illegal), 32'd1);
    check("ill_ready", 32'(in_ready), 32'd1);
    check("ill_we", 32'(mem_we), 32'd0);
    check("ill_count", 32'(count), 32'd2);
    waitReady();
    send(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0,
         1'b0, 1'b1, 2'd2, 32'h3464_00FF);
    waitReady();
    send(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0,
         1'b0, 1'b1, 2'd3, 32'h3000_0001);
    @(posedge clk);
    #1;
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    @(negedge clk);
    send(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0,
         1'b0, 1'b0, 2'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("full_nowrite", 32'(count), 32'd4);
    pulse(1'b0);
    check("full_done", {30'd0, full, done}, 32'd3);
    pulse(1'b1);
    check("clr_all", {count, full, done, err_illegal, in_ready},
          32'd1);

    // finish together with a legal handshake
    waitReady();
    send(4'd10, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0,
         1'b1, 1'b1, 2'd0, 32'hAC43_0008);
    @(posedge clk);
    #1;
    check("sim_done", 32'(done), 32'd1);
    check("sim_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("sim_count", 32'(count), 32'd1);
    pulse(1'b1);

    // reset asserted during WRITE
    waitReady();
    send(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0,
         1'b0, 1'b0, 2'd0, 32'h0);
    check("pre_rst_we", 32'(mem_we), 32'd1);
    check("pre_rst_wdata", mem_wdata, 32'h2822_0003);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_wdata", mem_wdata, 32'd0);
    check("rst_mid_state",
          {count, mem_addr, full, done, err_illegal, in_ready},
          32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_count", 32'(count), 32'd0);
    check("sb_drain", 32'(expDataQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
